raster_walker: RTL

- Pixel-stream generator that feeds the pixel processing unit.
- Accepts one triangle job per handshake: screen bounding box, 3x3 edge-plane coefficients and a flat colour.
- Walks every pixel of the box in raster order. Emits (x, y, bounds, colour) one pixel per cycle on a valid/ready stream whose payload drives the PPU inputs directly.
- Sits between triangle setup (upstream) and the PPU array (downstream).

---
 rtl/gpu_pkg.sv | 20 ++
 rtl/raster_walker.sv | 137 +++++++++++++
 2 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU front-end types: coordinate/colour widths, edge-plane
// coefficient bundles and the raster walker state encoding.
package gpu_pkg;

    localparam int COORD_WIDTH = 16;
    localparam int COLOR_WIDTH = 16;

    typedef logic [COORD_WIDTH-1:0] coord_t;
    typedef logic [COLOR_WIDTH-1:0] color_t;

    // One edge plane {a, b, c}; three planes bound a triangle.
    typedef coord_t [2:0] plane_t;
    typedef plane_t [2:0] bounds_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } walker_state_e;

endpackage : gpu_pkg

// File: rtl/raster_walker.sv
// Raster walker: accepts one triangle job (bounding box, edge planes,
// flat colour) and streams every pixel of the box, one per cycle, to the
// pixel processing unit over a valid/ready interface.
//
// Build option: define RASTER_SERPENTINE_EN for a boustrophedon walk
// (odd rows, counted from ymin, run from xmax down to xmin).
module raster_walker
    import gpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    tri_valid,
    output logic    tri_ready,
    input  coord_t  tri_xmin,
    input  coord_t  tri_xmax,
    input  coord_t  tri_ymin,
    input  coord_t  tri_ymax,
    input  bounds_t tri_bounds,
    input  color_t  tri_color,
    output logic    pix_valid,
    input  logic    pix_ready,
    output coord_t  pix_x,
    output coord_t  pix_y,
    output bounds_t pix_bounds,
    output color_t  pix_color,
    output logic    pix_last,
    output logic    busy
);

    walker_state_e state;
    coord_t        xmin_q;
    coord_t        xmax_q;
    coord_t        ymax_q;
    coord_t        next_x;
    coord_t        next_y;
    logic          next_last;
    logic          scan_done;
    logic          box_ok;
`ifdef RASTER_SERPENTINE_EN
    logic          row_odd;
    logic          next_odd;
`endif

    assign tri_ready = (state == IDLE);
    assign box_ok    = (tri_xmin <= tri_xmax) && (tri_ymin <= tri_ymax);

    // Next pixel position; steps by equality against the bound so a box
    // ending at the top of the coordinate range never wraps.
    always_comb begin
        next_x    = pix_x;
        next_y    = pix_y;
        scan_done = 1'b0;
`ifdef RASTER_SERPENTINE_EN
        next_odd  = row_odd;
        if (pix_x != (row_odd ? xmin_q : xmax_q)) begin
            next_x = row_odd ? (pix_x - coord_t'(1)) : (pix_x + coord_t'(1));
        end else if (pix_y != ymax_q) begin
            next_y   = pix_y + coord_t'(1);
            next_odd = !row_odd;
        end else begin
            scan_done = 1'b1;
        end
        next_last = (next_x == (next_odd ? xmin_q : xmax_q)) && (next_y == ymax_q);
`else
        if (pix_x != xmax_q) begin
            next_x = pix_x + coord_t'(1);
        end else if (pix_y != ymax_q) begin
            next_x = xmin_q;
            next_y = pix_y + coord_t'(1);
        end else begin
            scan_done = 1'b1;
        end
        next_last = (next_x == xmax_q) && (next_y == ymax_q);
`endif
    end

    // Job acceptance, pixel stepping and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymax_q     <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_bounds <= '0;
            pix_color  <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            busy       <= 1'b0;
`ifdef RASTER_SERPENTINE_EN
            row_odd    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Empty boxes are dropped without touching the payload.
                    if (tri_valid && box_ok) begin
                        xmin_q     <= tri_xmin;
                        xmax_q     <= tri_xmax;
                        ymax_q     <= tri_ymax;
                        pix_x      <= tri_xmin;
                        pix_y      <= tri_ymin;
                        pix_bounds <= tri_bounds;
                        pix_color  <= tri_color;
                        pix_last   <= (tri_xmin == tri_xmax) && (tri_ymin == tri_ymax);
                        pix_valid  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SCAN;
`ifdef RASTER_SERPENTINE_EN
                        row_odd    <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    if (pix_ready) begin
                        if (scan_done) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            pix_x    <= next_x;
                            pix_y    <= next_y;
                            pix_last <= next_last;
`ifdef RASTER_SERPENTINE_EN
                            row_odd  <= next_odd;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : raster_walker
